// File: rtl/hsi_pkg.sv
// Constants and state encodings for the HSI serial link, shared by the
// slave and master sides.
package hsi_pkg;

  localparam int BIT_CLKS_DEF = 8;   // clk cycles per line bit
  localparam int FRAME_BITS   = 10;  // start + 8 data + parity
  localparam int GAP_BITS     = 2;   // idle bits after each transmitted frame

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_ARM_WAIT = 2'd0,
    RX_ARMED    = 2'd1,
    RX_RECV     = 2'd2
  } rx_state_t;

  // Parity bit that makes the count of ones in data plus parity odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/hsi_s_rx_dec.sv
// Manchester command receiver: synchronizes both com lines, waits for a quiet
// line before arming, samples each bit twice and checks code and parity.
module hsi_s_rx_dec
  import hsi_pkg::*;
#(
  parameter int BIT_CLKS = BIT_CLKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       com_src,
  input  logic       com1,
  input  logic       com2,
  output logic [7:0] q,
  output logic       q_rdy,
  output logic       rx_err
);

  localparam int PW = $clog2(BIT_CLKS);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CLKS - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(BIT_CLKS / 4);
  localparam logic [PW-1:0] PH_S2   = PW'(3 * BIT_CLKS / 4);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);
  localparam logic [BW-1:0] BIT_PAR = BW'(FRAME_BITS - 1);

  rx_state_t       state, state_next;
  logic [1:0]      c1_sync, c2_sync;
  logic            src_q, sel, line;
  logic [PW-1:0]   zero_cnt, phase;
  logic [BW-1:0]   bit_idx;
  logic            h1, par_acc;
  logic [7:0]      shreg;
  logic            at_s1, at_s2, code_err, frame_end;

  // Both lines are synchronized so the selection can move without a re-sync delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_sync <= '0;
      c2_sync <= '0;
    end else begin
      c1_sync <= {c1_sync[0], com1};
      c2_sync <= {c2_sync[0], com2};
    end
  end

  // The source is frozen for the duration of a frame.
  assign sel  = (state == RX_RECV) ? src_q : com_src;
  assign line = sel ? c2_sync[1] : c1_sync[1];

  always_ff @(posedge clk) begin
    if (rst) state <= RX_ARM_WAIT;
    else     state <= state_next;
  end

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    at_s1     = 1'b0;
    at_s2     = 1'b0;
    code_err  = 1'b0;
    frame_end = 1'b0;
    if (state == RX_RECV) begin
      at_s1     = (phase == PH_S1);
      at_s2     = (phase == PH_S2);
      code_err  = at_s2 && ((h1 == line) || (bit_idx == '0 && !h1));
      frame_end = at_s2 && (code_err || bit_idx == BIT_PAR);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_ARM_WAIT: if (!line && zero_cnt == PH_LAST) state_next = RX_ARMED;
      RX_ARMED:    if (line) state_next = RX_RECV;
      RX_RECV:     if (frame_end) state_next = RX_ARM_WAIT;
      default:     state_next = RX_ARM_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt <= '0;
      phase    <= '0;
      bit_idx  <= '0;
      h1       <= 1'b0;
      par_acc  <= 1'b0;
      shreg    <= '0;
      src_q    <= 1'b0;
      q        <= '0;
      q_rdy    <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      q_rdy  <= 1'b0;
      rx_err <= 1'b0;
      case (state)
        RX_ARM_WAIT: begin
          zero_cnt <= (line || zero_cnt == PH_LAST) ? '0 : zero_cnt + PH_ONE;
        end
        RX_ARMED: begin
          // The rising edge is count 0, so the first RECV cycle is count 1.
          phase   <= PH_ONE;
          bit_idx <= '0;
          par_acc <= 1'b0;
          src_q   <= com_src;
        end
        RX_RECV: begin
          phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
          if (phase == PH_LAST) bit_idx <= bit_idx + BIT_ONE;
          if (at_s1) h1 <= line;
          if (at_s2 && !code_err && bit_idx != '0 && bit_idx != BIT_PAR) begin
            shreg   <= {shreg[6:0], h1};
            par_acc <= par_acc ^ h1;
          end
          if (frame_end) begin
            zero_cnt <= '0;
            if (code_err || !(par_acc ^ h1)) begin
              rx_err <= 1'b1;
            end else begin
              q     <= shreg;
              q_rdy <= 1'b1;
            end
          end
        end
        default: zero_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/hsi_slave.sv
// HSI slave: Manchester command receiver plus a full-duplex data transmitter
// that sends one framed byte followed by an idle gap.
module hsi_slave
  import hsi_pkg::*;
#(
  parameter int BIT_CLKS = BIT_CLKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       com_src,
  input  logic       com1,
  input  logic       com2,
  output logic [7:0] q,
  output logic       q_rdy,
  output logic       rx_err,
  input  logic [7:0] tx_d,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       dat1,
  output logic       dat2
);

  localparam int PW = $clog2(BIT_CLKS);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int GW = $clog2(GAP_BITS * BIT_CLKS);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CLKS - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(BIT_CLKS / 2);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS * BIT_CLKS - 1);

  hsi_s_rx_dec #(.BIT_CLKS(BIT_CLKS)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .com_src (com_src),
    .com1    (com1),
    .com2    (com2),
    .q       (q),
    .q_rdy   (q_rdy),
    .rx_err  (rx_err)
  );

  tx_state_t             state, state_next;
  logic [PW-1:0]         phase;
  logic [BW-1:0]         bit_idx;
  logic [GW-1:0]         gap_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  accept, bit_end, line_out;

  assign accept  = (state == TX_IDLE) && tx_vld && tx_rdy;
  assign bit_end = (phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: if (accept) state_next = TX_SEND;
      TX_SEND: if (bit_end && bit_idx == BIT_LAST) state_next = TX_GAP;
      TX_GAP:  if (gap_cnt == GAP_LAST) state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      frame   <= '0;
      tx_rdy  <= 1'b0;
    end else begin
      // Registered so it stays low through reset and rises one edge after release.
      tx_rdy <= (state_next == TX_IDLE);
      case (state)
        TX_IDLE: begin
          if (accept) begin
            frame   <= {1'b1, tx_d, odd_par(tx_d)};
            phase   <= '0;
            bit_idx <= '0;
          end
        end
        TX_SEND: begin
          phase   <= bit_end ? '0 : phase + PH_ONE;
          gap_cnt <= '0;
          if (bit_end) begin
            bit_idx <= bit_idx + BIT_ONE;
            frame   <= {frame[FRAME_BITS-2:0], 1'b0};
          end
        end
        TX_GAP:  gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_ONE;
        default: gap_cnt <= '0;
      endcase
    end
  end

  // '1' is high-then-low, '0' is low-then-high; the line idles low.
  always_comb begin
    line_out = 1'b0;
    if (state == TX_SEND) line_out = frame[FRAME_BITS-1] ^ (phase >= PH_HALF);
  end

  assign dat1 = line_out;
  assign dat2 = line_out;

endmodule

// File: tb/tb_hsi_slave.sv
// Bench for hsi_slave: directed and random Manchester frames checked against a
// waveform-level reference decoder, plus transmitted-frame checks from logged dat lines.
module tb_hsi_slave;
  import hsi_pkg::*;

  localparam int B    = 8;
  localparam int MAXC = 20000;

  logic       clk = 1'b0, rst = 1'b1, com_src = 1'b0, com1 = 1'b0, com2 = 1'b0;
  logic       tx_vld = 1'b0;
  logic [7:0] tx_d = 8'h00;
  logic [7:0] q;
  logic       q_rdy, rx_err, tx_rdy, dat1, dat2;

  hsi_slave #(.BIT_CLKS(B)) dut (
    .clk(clk), .rst(rst), .com_src(com_src), .com1(com1), .com2(com2),
    .q(q), .q_rdy(q_rdy), .rx_err(rx_err),
    .tx_d(tx_d), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .dat1(dat1), .dat2(dat2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { int cyc; bit err; bit both; logic [7:0] q; } ev_t;
  typedef struct { int cyc; bit err; logic [7:0] q; } mev_t;
  typedef struct { int e0; logic [7:0] d; } acc_t;

  logic dat1_log [MAXC];
  logic dat2_log [MAXC];
  logic rdy_log  [MAXC];
  ev_t  ev_q [$];
  mev_t exp_q [$];
  acc_t acc_q [$];
  bit   wv [$];
  logic [7:0] model_q = 8'h00;
  bit   tx_auto = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (cyc < MAXC) begin
      dat1_log[cyc] = dat1;
      dat2_log[cyc] = dat2;
      rdy_log[cyc]  = tx_rdy;
    end
    if (q_rdy === 1'b1 || rx_err === 1'b1) begin
      e.cyc  = cyc;
      e.err  = (rx_err === 1'b1);
      e.both = (q_rdy === 1'b1) && (rx_err === 1'b1);
      e.q    = q;
      ev_q.push_back(e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- waveform construction ----------------
  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) wv.push_back(1'b0);
  endfunction

  function automatic void add_bit(input bit b);
    for (int h = 0; h < B; h++) wv.push_back(b ? (h < B/2) : (h >= B/2));
  endfunction

  function automatic void add_hold(input bit v);
    for (int h = 0; h < B; h++) wv.push_back(v);
  endfunction

  function automatic bit par_of(input logic [7:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  // hold_idx >= 0 replaces that frame bit with a constant level hold_val.
  function automatic void add_frame(input logic [7:0] d, input bit bad_par,
                                    input int hold_idx, input bit hold_val);
    logic [9:0] f;
    f = {1'b1, d, par_of(d) ^ bad_par};
    for (int i = 0; i < 10; i++) begin
      if (i == hold_idx) add_hold(hold_val);
      else add_bit(f[9-i]);
    end
  endfunction

  function automatic bit at(input int x);
    return (x < wv.size()) ? wv[x] : 1'b0;
  endfunction

  // Reference decoder over the whole line waveform: quiet run arms, a high
  // level starts a frame, two samples per bit; strobe lands 3 cycles after the
  // sample index (2 synchronizer stages plus the registered strobe).
  function automatic void model(input int p0);
    int zeros, i, t0, j, ones, n;
    bit armed, a, c;
    logic [7:0] d;
    mev_t m;
    exp_q.delete();
    zeros = 0; armed = 1'b0; i = 0; n = wv.size();
    while (i < n) begin
      if (!armed) begin
        zeros = wv[i] ? 0 : zeros + 1;
        if (zeros >= B) armed = 1'b1;
        i++;
      end else if (!wv[i]) begin
        i++;
      end else begin
        t0 = i; d = 8'h00; ones = 0; m.err = 1'b0; j = t0;
        for (int b = 0; b < 10; b++) begin
          a = at(t0 + b*B + B/4);
          c = at(t0 + b*B + 3*B/4);
          j = t0 + b*B + 3*B/4;
          if (a == c || (b == 0 && !a)) begin
            m.err = 1'b1;
            break;
          end
          if (b > 0) ones += int'(a);
          if (b >= 1 && b <= 8) d = {d[6:0], a};
          if (b == 9) m.err = (ones % 2 == 0);
        end
        if (!m.err) model_q = d;
        m.cyc = p0 + j + 3;
        m.q   = model_q;
        exp_q.push_back(m);
        armed = 1'b0; zeros = 0; i = j + 1;
      end
    end
  endfunction

  task automatic tx_service();
    acc_t a;
    if (tx_auto) begin
      if (tx_vld) tx_vld = 1'b0;
      else if (tx_rdy === 1'b1) begin
        tx_d   = 8'($urandom);
        tx_vld = 1'b1;
        a.e0 = cyc + 1;
        a.d  = tx_d;
        acc_q.push_back(a);
      end
    end
  endtask

  task automatic play(input bit on2, input int chg_at, output int p0);
    p0 = 0;
    for (int k = 0; k < wv.size(); k++) begin
      @(negedge clk);
      if (k == 0) p0 = cyc;
      if (k == chg_at) com_src = ~com_src;
      if (on2) com2 = wv[k];
      else     com1 = wv[k];
      tx_service();
    end
    com1 = 1'b0;
    com2 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      tx_service();
    end
  endtask

  task automatic get_act(input int p0, output ev_t act[$]);
    act.delete();
    foreach (ev_q[i])
      if (ev_q[i].cyc >= p0 && ev_q[i].cyc < p0 + wv.size() + 4) act.push_back(ev_q[i]);
  endtask

  task automatic compare(input string tag, input int p0);
    ev_t act[$];
    get_act(p0, act);
    chk({tag, " event count"}, act.size(), exp_q.size());
    for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
      chk({tag, " event cycle"}, act[i].cyc - p0, exp_q[i].cyc - p0);
      chk({tag, " event is_err"}, act[i].err, exp_q[i].err);
      chk({tag, " event q"}, act[i].q, exp_q[i].q);
      chk({tag, " q_rdy+rx_err together"}, act[i].both, 0);
    end
  endtask

  task automatic count_kinds(input int p0, output int n_rdy, output int n_err);
    ev_t act[$];
    get_act(p0, act);
    n_rdy = 0; n_err = 0;
    foreach (act[i]) begin
      if (act[i].err) n_err++;
      else n_rdy++;
    end
  endtask

  // Checks the Manchester frame from acceptance cycle e0 for n_cyc cycles
  // (frame then zeros), and optionally the tx_rdy low window.
  task automatic check_tx(input string tag, input int e0, input logic [7:0] d,
                          input int n_cyc, input bit chk_rdy);
    logic [9:0] f;
    int mism, lowc, k;
    bit e;
    f = {1'b1, d, par_of(d)};
    mism = 0;
    for (k = 0; k < n_cyc; k++) begin
      e = (k < 10*B) ? (f[9 - k/B] ? (k % B < B/2) : (k % B >= B/2)) : 1'b0;
      if (dat1_log[e0+k] !== e || dat2_log[e0+k] !== e) mism++;
    end
    chk({tag, " dat mismatches"}, mism, 0);
    if (chk_rdy) begin
      lowc = 0;
      for (k = 0; k < 12*B; k++) if (rdy_log[e0+k] === 1'b0) lowc++;
      chk({tag, " tx_rdy low cycles"}, lowc, 12*B);
      chk({tag, " tx_rdy back"}, rdy_log[e0 + 12*B], 1);
    end
  endtask

  task automatic wait_tx_rdy(input string tag);
    int n;
    n = 0;
    while (tx_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " tx_rdy wait"}, tx_rdy, 1);
  endtask

  initial begin
    int p0, e0, n_rdy, n_err, mism;
    ev_t act[$];

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst dat1", dat1, 0);
    chk("rst dat2", dat2, 0);
    chk("rst tx_rdy", tx_rdy, 0);
    chk("rst q", q, 8'h00);
    chk("rst q_rdy", q_rdy, 0);
    chk("rst rx_err", rx_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tx_rdy after release", tx_rdy, 1);
    repeat (4) @(negedge clk);

    // ---- good frame 3C on com1 ----
    wv.delete(); add_idle(2*B); add_frame(8'h3C, 0, -1, 0); add_idle(14*B);
    play(0, -1, p0); model(p0); compare("good3C", p0);
    count_kinds(p0, n_rdy, n_err);
    chk("good3C q_rdy pulses", n_rdy, 1);
    chk("good3C rx_err pulses", n_err, 0);
    chk("good3C q", q, 8'h3C);

    // ---- parity error then 81 after exactly B idle cycles ----
    wv.delete(); add_idle(2*B); add_frame(8'h3C, 1, -1, 0); add_idle(B);
    add_frame(8'h81, 0, -1, 0); add_idle(14*B);
    play(0, -1, p0); model(p0); compare("parity", p0);
    get_act(p0, act);
    chk("parity first is err", (act.size() > 0) ? act[0].err : 1'b0, 1);
    chk("parity first q kept", (act.size() > 0) ? act[0].q : 8'hxx, 8'h3C);
    chk("after parity q", q, 8'h81);

    // ---- data bit 3 held high for a full bit ----
    wv.delete(); add_idle(2*B); add_frame(8'h3C, 0, 5, 1'b1); add_idle(14*B);
    play(0, -1, p0); model(p0); compare("hold", p0);
    get_act(p0, act);
    chk("hold first err cycle", (act.size() > 0) ? act[0].cyc - p0 : -1, 2*B + 5*B + 3*B/4 + 3);
    chk("hold first is err", (act.size() > 0) ? act[0].err : 1'b0, 1);
    count_kinds(p0, n_rdy, n_err);
    chk("hold q_rdy pulses", n_rdy, 0);
    chk("hold q kept", q, 8'h81);

    // ---- com_src=1: frame on com1 ignored, then on com2 received ----
    com_src = 1'b1;
    wv.delete(); add_idle(2*B); add_frame(8'h5A, 0, -1, 0); add_idle(14*B);
    play(0, -1, p0);
    count_kinds(p0, n_rdy, n_err);
    chk("src1 com1 q_rdy", n_rdy, 0);
    chk("src1 com1 rx_err", n_err, 0);
    play(1, -1, p0); model(p0); compare("src1 com2", p0);
    chk("src1 com2 q", q, 8'h5A);

    // ---- com_src flips mid-frame: current frame still completes ----
    com_src = 1'b0;
    wv.delete(); add_idle(2*B); add_frame(8'hC3, 0, -1, 0); add_idle(14*B);
    play(0, 2*B + 30, p0); model(p0); compare("src flip", p0);
    chk("src flip q", q, 8'hC3);
    com_src = 1'b0;
    repeat (2*B) @(negedge clk);

    // ---- TX A5 ----
    wait_tx_rdy("txA5");
    tx_d = 8'hA5; tx_vld = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (13*B) @(negedge clk);
    check_tx("txA5", e0, 8'hA5, 12*B, 1'b1);

    // ---- reset at TX cycle 40 of FF ----
    wait_tx_rdy("txFF");
    tx_d = 8'hFF; tx_vld = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    tx_vld = 1'b0;
    while (cyc < e0 + 39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_q = 8'h00;
    repeat (14*B) @(negedge clk);
    check_tx("txFF pre-reset", e0, 8'hFF, 40, 1'b0);
    mism = 0;
    for (int k = 40; k < 40 + 12*B; k++)
      if (dat1_log[e0+k] !== 1'b0 || dat2_log[e0+k] !== 1'b0) mism++;
    chk("txFF dat after reset", mism, 0);
    chk("txFF tx_rdy in reset", rdy_log[e0+40], 0);
    chk("txFF tx_rdy after release", rdy_log[e0+41], 1);
    chk("txFF q cleared", q, 8'h00);

    // ---- random frames on RX with concurrent random TX ----
    acc_q.delete();
    tx_auto = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bit on2;
      int kind;
      on2 = 1'($urandom_range(0, 1));
      com_src = on2;
      wv.delete(); add_idle(2*B);
      for (int f = 0; f < 6; f++) begin
        kind = $urandom_range(0, 9);
        if (kind < 7)       add_frame(8'($urandom), 0, -1, 0);
        else if (kind == 7) add_frame(8'($urandom), 1, -1, 0);
        else add_frame(8'($urandom), 0, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
        add_idle($urandom_range(2, 3*B));
      end
      add_idle(14*B);
      play(on2, -1, p0); model(p0); compare($sformatf("rand%0d", w), p0);
    end
    tx_auto = 1'b0;
    tx_vld  = 1'b0;
    repeat (14*B) @(negedge clk);
    chk("rand tx frames sent", acc_q.size() > 5, 1);
    foreach (acc_q[i])
      if (acc_q[i].e0 + 12*B + 1 < cyc && acc_q[i].e0 + 12*B + 1 < MAXC)
        check_tx($sformatf("randtx%0d", i), acc_q[i].e0, acc_q[i].d, 12*B, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsi_slave.md
HSI_SLAVE -- requirements
Module: hsi_slave

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 8, clk cycles per line bit; even, >=4.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port com_src  in  1  command line select: 0 = com1, 1 = com2.
REQ-005 SHALL have ports com1, com2  in  1 each  serial command lines from the HSI master; asynchronous.
REQ-006 SHALL have port q  out  8  last received command byte.
REQ-007 SHALL have port q_rdy  out  1  one-cycle strobe: q holds a new valid byte.
REQ-008 SHALL have port rx_err  out  1  one-cycle strobe: frame aborted on code or parity error.
REQ-009 SHALL have port tx_d  in  8  data byte to send.
REQ-010 SHALL have port tx_vld  in  1  tx_d valid.
REQ-011 SHALL have port tx_rdy  out  1  transmitter accepts a byte.
REQ-012 SHALL have ports dat1, dat2  out  1 each  serial data lines to the master; driven identically.

Function
REQ-013 Line frame SHALL be 10 bits, Manchester: start ('1'), 8 data bits MSB first, odd parity over the data bits (ones in data plus parity is odd).
REQ-014 Bit encoding SHALL be '1' = high for BIT_CLKS/2 cycles then low; '0' = low then high. The idle line SHALL be constant 0.
REQ-015 TX SHALL accept a byte when tx_vld & tx_rdy are both high at a clock edge; tx_d is captured at that edge and tx_rdy drops at the same edge.
REQ-016 dat1/dat2 SHALL present the first start half-bit from the edge after acceptance, for 10*BIT_CLKS cycles, then drive 0.
REQ-017 TX SHALL hold a 2*BIT_CLKS idle gap after the frame; tx_rdy SHALL reassert at the end of the gap, so accept-to-accept is at least 12*BIT_CLKS cycles.
REQ-018 TX states SHALL be IDLE, SEND and GAP. IDLE -> SEND on accept; SEND -> GAP after 10 bits; GAP -> IDLE after 2*BIT_CLKS cycles.
REQ-019 RX SHALL pass the selected com line through a 2-flop synchronizer; all RX timing below refers to the synchronized signal.
REQ-020 com_src SHALL be sampled only at frame start; a change mid-frame SHALL NOT affect the current frame.
REQ-021 RX SHALL arm only after the line has been 0 for at least BIT_CLKS consecutive cycles; arming also applies after reset.
REQ-022 An armed RX SHALL start a frame on a 0->1 transition, with the cycle counter at 0 on that cycle.
REQ-023 RX SHALL sample bit i (0..9) at counts i*BIT_CLKS + BIT_CLKS/4 and i*BIT_CLKS + 3*BIT_CLKS/4.
REQ-024 Equal halves in a bit, or a start bit that decodes as '0', SHALL abort the frame: rx_err pulses 1 cycle after the offending sample, q is unchanged, and RX disarms.
REQ-025 After the parity sample, RX SHALL pulse q_rdy for 1 cycle, starting the cycle after that sample, with q updated on the same cycle, when parity is correct. On a parity error it SHALL pulse rx_err instead and leave q unchanged.
REQ-026 RX states SHALL be ARM_WAIT, ARMED and RECV. After any frame end, RX SHALL return to ARM_WAIT.
REQ-027 TX and RX SHALL be fully independent (full duplex); simultaneous activity SHALL NOT interact.
REQ-028 q_rdy and rx_err SHALL never be high in the same cycle.

Reset
REQ-029 While rst is high, outputs SHALL be: dat1 = dat2 = 0, tx_rdy = 0, q = 8'h00, q_rdy = 0, rx_err = 0; TX in IDLE, RX in ARM_WAIT, counters 0.
REQ-030 tx_rdy SHALL rise at the first edge with rst low.
REQ-031 Reset mid-frame SHALL abandon the frame with no strobe; dat lines SHALL be 0 from the edge where rst is sampled high.

Structure
REQ-032 A shared package/include hsi_pkg SHALL hold the BIT_CLKS default, the frame length (10), the gap length (2 bits), and the TX/RX state encodings, shared with the master side.
REQ-033 The Manchester receiver (synchronizer, arming, sampling, parity) SHALL be one sub-module, hsi_s_rx_dec. The TX SHALL stay in hsi_slave.

Verification
REQ-034 BIT_CLKS=8, tx_d=8'hA5 accepted: dat1 = dat2 encode bits 1,1010_0101,1 over 80 cycles; tx_rdy low for 96 cycles.
REQ-035 com_src=0, frame 8'h3C (parity 1) on com1: q=8'h3C, exactly one q_rdy pulse, no rx_err.
REQ-036 Frame 8'h3C with parity bit 0: one rx_err pulse, no q_rdy, q unchanged; a following valid 8'h81 frame after 8+ idle cycles gives q=8'h81.
REQ-037 Data bit 3 held high for the full bit: rx_err at the bit-3 second sample +1; the rest of the frame is ignored.
REQ-038 com_src=1, frame on com1 only: no q_rdy or rx_err; the same frame on com2 gives q_rdy.
REQ-039 rst pulsed at TX cycle 40 of 8'hFF: dat = 0 next edge; tx_rdy = 1 after release; no further bits sent.
